// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses, edge-capture
// modes and the width of the post-reset arm counter.
package nios_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTRB   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Wide enough to count to SYNC_STAGES+1 for the largest legal depth (3).
    localparam int ARM_CNT_W = 3;

endpackage

// File: rtl/nios_system_pio_sync.sv
// Input synchroniser chain, last-value register and per-bit edge detector for
// the PIO input pins.
module nios_system_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);
    import nios_system_pio_pkg::*;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;

    // Stage 0 samples the pin; the oldest stage is the synchronised value.
    assign chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    assign sync_o  = chain_q[SYNC_STAGES-1];
    assign prev_d  = sync_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        edge_o = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_o = sync_o & ~prev_q;
            EDGE_FALL: edge_o = ~sync_o & prev_q;
            EDGE_ANY:  edge_o = sync_o ^ prev_q;
            default:   edge_o = '0;
        endcase
    end

endmodule

// File: rtl/nios_system_pio_gen2.sv
// Avalon-MM parallel I/O port: output register with set/clear aliases,
// synchronised inputs, sticky edge capture with W1C and masked level interrupt.
module nios_system_pio_gen2 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    import nios_system_pio_pkg::*;

    localparam logic [ARM_CNT_W-1:0] ARM_DONE = ARM_CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     out_q, out_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [WIDTH-1:0]     cap_q, cap_d;
    logic [ARM_CNT_W-1:0] arm_q, arm_d;

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] w1c;
    logic             we;
    logic             armed;

    nios_system_pio_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(in_port),
        .sync_o (sync_val),
        .edge_o (edge_vec)
    );

    assign we    = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];
    assign armed = (arm_q == ARM_DONE);
    assign w1c   = (we && address == ADDR_EDGECAP) ? wd : '0;

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        if (we) begin
            case (address)
                ADDR_DATA:    out_d  = wd;
                ADDR_OUTSET:  out_d  = out_q | wd;
                ADDR_OUTCLR:  out_d  = out_q & ~wd;
                ADDR_IRQMASK: mask_d = wd;
                default:      ;
            endcase
        end
    end

    // Set is applied after the clear so a coincident edge keeps the bit.
    always_comb begin
        cap_d = (cap_q & ~w1c) | (armed ? edge_vec : '0);
        arm_d = armed ? arm_q : arm_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= RESET_VALUE;
            mask_q <= '0;
            cap_q  <= '0;
            arm_q  <= '0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            arm_q  <= arm_d;
        end
    end

    assign out_port = out_q;
    assign irq      = |(cap_q & mask_q);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_val;
            ADDR_OUTRB:   readdata[WIDTH-1:0] = out_q;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_pio_gen2.sv
// Directed bench for the PIO: a rising-edge instance and an any-edge instance
// sharing clock, reset and the Avalon-MM write bus.
module tb_nios_system_pio_gen2;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [W-1:0] in_rise = '0;
  logic [W-1:0] in_any = '0;
  logic [31:0]  rd_rise, rd_any;
  logic [W-1:0] out_rise, out_any;
  logic         irq_rise, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_pio_gen2 #(
    .WIDTH(W), .RESET_VALUE(8'hA5), .SYNC_STAGES(2), .EDGE_TYPE(0)
  ) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_rise), .out_port(out_rise), .irq(irq_rise)
  );

  nios_system_pio_gen2 #(
    .WIDTH(W), .RESET_VALUE(8'hA5), .SYNC_STAGES(2), .EDGE_TYPE(2)
  ) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_any), .out_port(out_any), .irq(irq_any)
  );

  // Lands 1 ns after the rising edge; inputs are driven and outputs sampled here.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] r, output logic [31:0] r_any);
    address = a;
    #1;
    r     = rd_rise;
    r_any = rd_any;
  endtask

  task automatic test_reset();
    logic [31:0] r, ra;
    reset = 1'b1;
    tick(2);
    // Reset wins over a coincident write to DATA.
    address = 3'd0; writedata = 32'h0000_0000; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (out_rise !== 8'hA5) begin
      errors++; $display("FAIL reset_vs_write out_port=%h exp=a5", out_rise);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (out_rise !== 8'hA5) begin
      errors++; $display("FAIL reset_out out_port=%h exp=a5", out_rise);
    end
    checks++;
    if (irq_rise !== 1'b0) begin
      errors++; $display("FAIL reset_irq irq=%b exp=0", irq_rise);
    end
    bus_read(3'd1, r, ra);
    checks++;
    if (r !== 32'h0000_00A5) begin
      errors++; $display("FAIL reset_outrb readdata=%h exp=000000a5", r);
    end
    bus_read(3'd2, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL reset_mask readdata=%h exp=0", r);
    end
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL reset_edgecap readdata=%h exp=0", r);
    end
  endtask

  task automatic test_out_writes();
    logic [31:0] r, ra;
    bus_write(3'd0, 32'hFFFF_FF0F);
    checks++;
    if (out_rise !== 8'h0F) begin
      errors++; $display("FAIL out_data out_port=%h exp=0f", out_rise);
    end
    bus_write(3'd4, 32'h0000_00F0);
    checks++;
    if (out_rise !== 8'hFF) begin
      errors++; $display("FAIL out_set out_port=%h exp=ff", out_rise);
    end
    bus_write(3'd5, 32'h0000_0011);
    checks++;
    if (out_rise !== 8'hEE) begin
      errors++; $display("FAIL out_clr out_port=%h exp=ee", out_rise);
    end
    bus_write(3'd1, 32'h0000_0000);
    bus_write(3'd7, 32'h0000_0000);
    bus_write(3'd6, 32'h0000_0000);
    checks++;
    if (out_rise !== 8'hEE) begin
      errors++; $display("FAIL out_noeffect out_port=%h exp=ee", out_rise);
    end
    bus_read(3'd1, r, ra);
    checks++;
    if (r !== 32'h0000_00EE) begin
      errors++; $display("FAIL outrb_read readdata=%h exp=000000ee", r);
    end
    bus_read(3'd6, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL reserved_read readdata=%h exp=0", r);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] r, ra;
    bus_write(3'd2, 32'h0000_0001);
    bus_read(3'd2, r, ra);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++; $display("FAIL mask_read readdata=%h exp=1", r);
    end
    in_rise = 8'h01;   // transition just after edge k
    tick(1);           // edge k+1
    bus_read(3'd0, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL data_k1 readdata=%h exp=0", r);
    end
    tick(1);           // edge k+2
    bus_read(3'd0, r, ra);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++; $display("FAIL data_k2 readdata=%h exp=1", r);
    end
    checks++;
    if (irq_rise !== 1'b0) begin
      errors++; $display("FAIL irq_k2 irq=%b exp=0", irq_rise);
    end
    tick(1);           // edge k+3
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++; $display("FAIL edgecap_k3 readdata=%h exp=1", r);
    end
    checks++;
    if (irq_rise !== 1'b1) begin
      errors++; $display("FAIL irq_k3 irq=%b exp=1", irq_rise);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r, ra;
    in_rise = 8'h00;
    tick(4);
    in_rise = 8'h01;   // new edge at k
    tick(2);           // edge vector high until k+3
    bus_write(3'd3, 32'h0000_0001);
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0000_0001) begin
      errors++; $display("FAIL w1c_collide edgecap=%h exp=1", r);
    end
    checks++;
    if (irq_rise !== 1'b1) begin
      errors++; $display("FAIL w1c_collide_irq irq=%b exp=1", irq_rise);
    end
    bus_write(3'd3, 32'h0000_0001);
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL w1c_clear edgecap=%h exp=0", r);
    end
    checks++;
    if (irq_rise !== 1'b0) begin
      errors++; $display("FAIL w1c_clear_irq irq=%b exp=0", irq_rise);
    end
  endtask

  task automatic test_arm_period();
    logic [31:0] r, ra;
    in_rise = 8'hFF;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL arm_edgecap edgecap=%h exp=0", r);
    end
    bus_read(3'd0, r, ra);
    checks++;
    if (r !== 32'h0000_00FF) begin
      errors++; $display("FAIL arm_data readdata=%h exp=ff", r);
    end
    in_rise = 8'hF7;
    tick(4);
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL arm_fall_ignored edgecap=%h exp=0", r);
    end
    in_rise = 8'hFF;
    tick(4);
    bus_read(3'd3, r, ra);
    checks++;
    if (r !== 32'h0000_0008) begin
      errors++; $display("FAIL arm_bit3 edgecap=%h exp=8", r);
    end
  endtask

  task automatic test_any_edge();
    logic [31:0] r, ra;
    in_any = 8'h00;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    in_any = 8'h02;
    tick(4);
    bus_read(3'd3, r, ra);
    checks++;
    if (ra !== 32'h0000_0002) begin
      errors++; $display("FAIL any_rise edgecap=%h exp=2", ra);
    end
    bus_write(3'd3, 32'h0000_0002);
    in_any = 8'h00;
    tick(4);
    bus_read(3'd3, r, ra);
    checks++;
    if (ra !== 32'h0000_0002) begin
      errors++; $display("FAIL any_fall edgecap=%h exp=2", ra);
    end
    checks++;
    if (irq_any !== 1'b0) begin
      errors++; $display("FAIL any_irq_masked irq=%b exp=0", irq_any);
    end
    bus_write(3'd2, 32'h0000_0002);
    checks++;
    if (irq_any !== 1'b1) begin
      errors++; $display("FAIL any_irq_unmask irq=%b exp=1", irq_any);
    end
  endtask

  initial begin
    test_reset();
    test_out_writes();
    test_edge_irq();
    test_w1c_collision();
    test_arm_period();
    test_any_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_gen2.md
NIOS_SYSTEM_PIO_GEN2 -- requirements
Module: nios_system_pio_gen2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning port and register width, legal range 1..32.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the out_port value after reset, WIDTH bits.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning in_port synchroniser depth, legal range 2..3.
REQ-004 The block SHALL have parameter EDGE_TYPE, default 0, meaning capture edge: 0 rising, 1 falling, 2 any.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit; the block uses one clock, and reset is synchronous and active-high.
REQ-007 The block SHALL have port address, input, 3 bits, Avalon-MM word address.
REQ-008 The block SHALL have port chipselect, input, 1 bit, slave select.
REQ-009 The block SHALL have port write_n, input, 1 bit, active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32 bits, write data.
REQ-011 The block SHALL have port readdata, output, 32 bits, read data.
REQ-012 The block SHALL have port in_port, input, WIDTH bits, asynchronous external inputs.
REQ-013 The block SHALL have port out_port, output, WIDTH bits, registered external outputs.
REQ-014 The block SHALL have port irq, output, 1 bit, level interrupt to the processor.

Function
REQ-015 A write SHALL occur only on a rising clk edge with chipselect=1 and write_n=0; writedata[WIDTH-1:0] is used and the upper bits are ignored.
REQ-016 The register map SHALL be: 0 DATA (R: synced input, W: output); 1 OUTRB (R: out_port); 2 IRQMASK (R/W); 3 EDGECAP (R, W1C); 4 OUTSET (W: out |= wd); 5 OUTCLR (W: out &= ~wd); 6-7 reserved.
REQ-017 readdata SHALL be combinational, with zero wait states, and SHALL NOT depend on chipselect; bits [31:WIDTH] SHALL read 0; reads of 4-7 SHALL return 0.
REQ-018 Writes to OUTSET and OUTCLR SHALL update out_port on the next clk edge; writes to reserved addresses and OUTRB SHALL have no effect.
REQ-019 in_port SHALL pass through a SYNC_STAGES flop chain; DATA reads SHALL reflect an in_port change SYNC_STAGES edges later.
REQ-020 A prev register SHALL hold the last synced value; the edge vector SHALL be s&~prev (type 0), ~s&prev (type 1), or s^prev (type 2).
REQ-021 EDGECAP[i] SHALL set on the edge after edge[i] asserts, and SHALL clear only via a W1C write of 1 to bit i.
REQ-022 If a set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-023 irq SHALL equal |(EDGECAP & IRQMASK) combinationally; irq SHALL rise SYNC_STAGES+1 edges after the in_port transition.
REQ-024 Edge detection SHALL be disarmed for SYNC_STAGES+1 cycles after reset deasserts, driven by an arm counter; no EDGECAP bit sets while disarmed.
REQ-025 Pulses on in_port shorter than one clk period SHALL NOT be guaranteed to be captured.

Reset
REQ-026 While reset=1 at a clk edge, out_port SHALL become RESET_VALUE, and IRQMASK, EDGECAP, the sync chain and prev SHALL become 0.
REQ-027 While reset=1 at a clk edge, the arm counter SHALL become 0 and irq SHALL be 0 from the following cycle.
REQ-028 Reset SHALL take priority over any simultaneous write; a mid-operation reset SHALL discard pending edges.

Structure
REQ-029 The package nios_system_pio_pkg SHALL hold the address constants ADDR_DATA..ADDR_OUTCLR and the edge-type constants EDGE_RISE, EDGE_FALL and EDGE_ANY.
REQ-030 The submodule nios_system_pio_sync SHALL implement the synchroniser, prev register and edge vector, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE; the top SHALL hold the registers, arm counter and read mux.

Verification
REQ-031 The bench SHALL check: reset with RESET_VALUE=0xA5, WIDTH=8 -> out_port=0xA5, readdata@1=0x000000A5, irq=0.
REQ-032 The bench SHALL check: write DATA=0x0F, then OUTSET=0xF0, then OUTCLR=0x11 -> out_port values 0x0F, then 0xFF, then 0xEE, each one edge after its write.
REQ-033 The bench SHALL check: IRQMASK=0x01, in_port bit0 0->1 at edge k, EDGE_TYPE=0 -> EDGECAP=0x01 and irq=1 after edge k+3; DATA reads 0x01 after edge k+2.
REQ-034 The bench SHALL check: a W1C of EDGECAP=0x01 in the same cycle as a new bit0 edge -> EDGECAP stays 0x01 and irq stays 1.
REQ-035 The bench SHALL check: in_port=0xFF held through reset, EDGE_TYPE=0 -> EDGECAP=0 after the arm period; a later 1->0->1 on bit3 sets EDGECAP=0x08.
REQ-036 The bench SHALL check: EDGE_TYPE=2, bit1 toggling twice with mask 0 -> EDGECAP=0x02 and irq=0; a later IRQMASK=0x02 write -> irq=1 on the next cycle.
